key_voice_alloc: RTL and testbench

- Sits between the PS/2 keyboard byte receiver and the four-channel scan-code-to-frequency staff decoder.
- Turns the serial PS/2 set-2 make/break byte stream into four held-key slots (`scan_code1..4`), giving up to 4-note polyphony.
- An idle slot outputs 8'hF0, the staff stage's "sound off" code.
- Handles break/extended/pause prefixes, typematic repeats, channel-full overflow and an optional stuck-key timeout.

---
 rtl/key_voice_alloc.sv | 143 ++++++++++++++
 tb/tb_key_voice_alloc.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/key_voice_alloc.sv
// PS/2 set-2 byte stream to four held-key voice slots (4-note polyphony).
// Idle slots output 8'hF0, the staff decoder's "sound off" code.
module key_voice_alloc #(
  parameter int unsigned HOLD_TIMEOUT = 0,
  parameter int unsigned TO_W         = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] scan_code1,
  output logic [7:0] scan_code2,
  output logic [7:0] scan_code3,
  output logic [7:0] scan_code4,
  output logic [3:0] active,
  output logic       overflow
);

  typedef enum logic [2:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK,
    PAUSE
  } state_e;

  localparam logic [7:0]      SOUND_OFF = 8'hF0;
  localparam logic [TO_W-1:0] TO_LOAD   = TO_W'(HOLD_TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);
  localparam bit              TO_EN     = (HOLD_TIMEOUT != 0);

  state_e          state_q;
  logic [2:0]      pause_q;
  logic [7:0]      slot_q [4];
  logic [TO_W-1:0] cnt_q  [4];
  logic [3:0]      active_q;
  logic            overflow_q;

  // Byte classification; anything outside these classes is ignored everywhere.
  logic is_make, is_f0, is_e0, is_e1, byte_ok;
  assign is_make = (rx_data >= 8'h01) && (rx_data <= 8'h83);
  assign is_f0   = (rx_data == 8'hF0);
  assign is_e0   = (rx_data == 8'hE0);
  assign is_e1   = (rx_data == 8'hE1);
  assign byte_ok = rx_valid && (is_make || is_f0 || is_e0 || is_e1);

  logic do_make, do_break;
  assign do_make  = byte_ok && is_make && (state_q == IDLE);
  assign do_break = byte_ok && is_make && (state_q == BRK);

  logic [3:0] hit, expire, alloc;
  logic       any_hit, new_make, found;

  always_comb begin
    hit    = '0;
    expire = '0;
    for (int i = 0; i < 4; i++) begin
      hit[i]    = active_q[i] && (slot_q[i] == rx_data);
      expire[i] = TO_EN && active_q[i] && (cnt_q[i] == TO_ONE);
    end
  end

  assign any_hit  = |hit;
  assign new_make = do_make && !any_hit;

  // Allocation sees occupancy at the start of the cycle, so a slot timing
  // out this cycle is still busy and cannot take a new key.
  always_comb begin
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (new_make && !active_q[i] && !found) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values no matter the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pause_q    <= '0;
      active_q   <= '0;
      overflow_q <= 1'b0;
      // NOTE: the slot and counter arrays are only a few flops, so they are
      // reset explicitly; their contents drive outputs directly.
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= SOUND_OFF;
        cnt_q[i]  <= '0;
      end
    end else begin
      overflow_q <= new_make && (active_q == 4'hF);

      if (byte_ok) begin
        unique case (state_q)
          IDLE: begin
            if (is_f0) state_q <= BRK;
            else if (is_e0) state_q <= EXT;
            else if (is_e1) begin
              state_q <= PAUSE;
              pause_q <= 3'd7;
            end
          end
          BRK:     if (!is_f0) state_q <= IDLE;
          EXT:     state_q <= is_f0 ? EXT_BRK : IDLE;
          EXT_BRK: state_q <= IDLE;
          PAUSE: begin
            pause_q <= pause_q - 3'd1;
            if (pause_q == 3'd1) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end

      // A repeat make beats a same-cycle timeout; break and timeout merge.
      for (int i = 0; i < 4; i++) begin
        if (do_make && hit[i]) begin
          cnt_q[i] <= TO_LOAD;
        end else if (alloc[i]) begin
          slot_q[i]   <= rx_data;
          active_q[i] <= 1'b1;
          cnt_q[i]    <= TO_LOAD;
        end else if ((do_break && hit[i]) || expire[i]) begin
          slot_q[i]   <= SOUND_OFF;
          active_q[i] <= 1'b0;
          cnt_q[i]    <= '0;
        end else if (TO_EN && active_q[i]) begin
          cnt_q[i] <= cnt_q[i] - TO_ONE;
        end
      end
    end
  end

  assign scan_code1 = slot_q[0];
  assign scan_code2 = slot_q[1];
  assign scan_code3 = slot_q[2];
  assign scan_code4 = slot_q[3];
  assign active     = active_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_key_voice_alloc.sv
// Directed bench for key_voice_alloc: allocation, overflow, prefixes,
// typematic repeats, stuck-key timeout and mid-sequence reset.
module tb_key_voice_alloc;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] scan_code1, scan_code2, scan_code3, scan_code4;
  logic [3:0] active;
  logic       overflow;

  int passed = 0;
  int total  = 0;

  key_voice_alloc #(.HOLD_TIMEOUT(100), .TO_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .scan_code1 (scan_code1),
    .scan_code2 (scan_code2),
    .scan_code3 (scan_code3),
    .scan_code4 (scan_code4),
    .active     (active),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_slots(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3, input logic [7:0] e4, input logic [3:0] ea);
    check({tag, ".sc1"}, 32'(scan_code1), 32'(e1));
    check({tag, ".sc2"}, 32'(scan_code2), 32'(e2));
    check({tag, ".sc3"}, 32'(scan_code3), 32'(e3));
    check({tag, ".sc4"}, 32'(scan_code4), 32'(e4));
    check({tag, ".act"}, 32'(active), 32'(ea));
  endtask

  // Caller is at a negedge; the byte is strobed for exactly one cycle and its
  // effect is visible at the following negedge, where this task returns.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_slots("reset", 8'hF0, 8'hF0, 8'hF0, 8'hF0, 4'b0000);
    check("reset.ovf", 32'(overflow), 32'd0);

    // Lowest-index allocation, one cycle after each strobe
    send(8'h1C);
    check_slots("alloc1", 8'h1C, 8'hF0, 8'hF0, 8'hF0, 4'b0001);
    send(8'h1B);
    check_slots("alloc2", 8'h1C, 8'h1B, 8'hF0, 8'hF0, 4'b0011);
    send(8'h23);
    check_slots("alloc3", 8'h1C, 8'h1B, 8'h23, 8'hF0, 4'b0111);

    // Channel full: overflow pulses for one cycle, nothing stolen
    send(8'h2B);
    check_slots("full", 8'h1C, 8'h1B, 8'h23, 8'h2B, 4'b1111);
    check("full.ovf", 32'(overflow), 32'd0);
    send(8'h34);
    check("ovf.pulse", 32'(overflow), 32'd1);
    check_slots("ovf", 8'h1C, 8'h1B, 8'h23, 8'h2B, 4'b1111);
    @(negedge clk);
    check("ovf.clear", 32'(overflow), 32'd0);

    // Break frees slot 1, next make reuses it
    send(8'hF0);
    check_slots("brk.pfx", 8'h1C, 8'h1B, 8'h23, 8'h2B, 4'b1111);
    send(8'h1B);
    check_slots("brk", 8'h1C, 8'hF0, 8'h23, 8'h2B, 4'b1101);
    send(8'h34);
    check_slots("reuse", 8'h1C, 8'h34, 8'h23, 8'h2B, 4'b1111);
    check("reuse.ovf", 32'(overflow), 32'd0);

    // Typematic repeats never duplicate; break of an unheld key is a no-op
    do_reset();
    send(8'h1C);
    send(8'h1B);
    send(8'h1C);
    send(8'h1C);
    send(8'h1C);
    check_slots("repeat", 8'h1C, 8'h1B, 8'hF0, 8'hF0, 4'b0011);
    send(8'hF0);
    send(8'h42);
    check_slots("brk.unheld", 8'h1C, 8'h1B, 8'hF0, 8'hF0, 4'b0011);
    // Double F0 stays in break state, then releases 1C
    send(8'hF0);
    send(8'hF0);
    send(8'h1C);
    check_slots("brk.f0f0", 8'hF0, 8'h1B, 8'hF0, 8'hF0, 4'b0010);

    // Extended, pause and ignored bytes never touch slots
    do_reset();
    send(8'hE0);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check_slots("ext", 8'hF0, 8'hF0, 8'hF0, 8'hF0, 4'b0000);
    send(8'hE1);
    send(8'h14);
    send(8'h77);
    send(8'hE1);
    send(8'hF0);
    send(8'h14);
    send(8'hF0);
    send(8'h77);
    check_slots("pause", 8'hF0, 8'hF0, 8'hF0, 8'hF0, 4'b0000);
    send(8'hAA);
    send(8'h90);
    check_slots("ignored", 8'hF0, 8'hF0, 8'hF0, 8'hF0, 4'b0000);
    send(8'h1C);
    check_slots("post.pause", 8'h1C, 8'hF0, 8'hF0, 8'hF0, 4'b0001);

    // Stuck-key timeout: release exactly 100 cycles after the load edge
    do_reset();
    send(8'h1C);
    repeat (99) @(negedge clk);
    check_slots("to.before", 8'h1C, 8'hF0, 8'hF0, 8'hF0, 4'b0001);
    @(negedge clk);
    check_slots("to.release", 8'hF0, 8'hF0, 8'hF0, 8'hF0, 4'b0000);

    // Repeats every 50 cycles keep the slot alive
    do_reset();
    send(8'h1C);
    for (int k = 0; k < 4; k++) begin
      repeat (49) @(negedge clk);
      send(8'h1C);
    end
    repeat (90) @(negedge clk);
    check_slots("to.refresh", 8'h1C, 8'hF0, 8'hF0, 8'hF0, 4'b0001);
    repeat (10) @(negedge clk);
    check_slots("to.refresh.end", 8'hF0, 8'hF0, 8'hF0, 8'hF0, 4'b0000);

    // Reset right after a break prefix: the next byte is a fresh make
    do_reset();
    send(8'h1B);
    send(8'hF0);
    do_reset();
    check_slots("rst.mid", 8'hF0, 8'hF0, 8'hF0, 8'hF0, 4'b0000);
    send(8'h1C);
    check_slots("rst.fresh", 8'h1C, 8'hF0, 8'hF0, 8'hF0, 4'b0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
